// File: rtl/i2c_reg_target.sv
// I2C register target: 7-bit ID match, 16-bit register pointer, write strobes
// and auto-incrementing reads served from an external register store.
module i2c_reg_target #(
   parameter logic [6:0] I2C_ID     = 7'h10,
   parameter int         FILTER_LEN = 3,
   parameter int         HOLD_CYC   = 4
) (
   input  logic        i_sysclk,
   input  logic        i_arst,
   input  logic        i_scl,
   input  logic        i_sda,
   output logic        o_sda_oe,
   output logic        o_wr_en,
   output logic [15:0] o_wr_addr,
   output logic [7:0]  o_wr_data,
   output logic        o_rd_req,
   output logic [15:0] o_rd_addr,
   input  logic [7:0]  i_rd_data,
   output logic        o_busy,
   output logic [2:0]  o_state
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int HW = $clog2(HOLD_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ADDR     = 3'd1,
      S_ADDR_ACK = 3'd2,
      S_RX       = 3'd3,
      S_RX_ACK   = 3'd4,
      S_TX       = 3'd5,
      S_TX_ACK   = 3'd6,
      S_IGNORE   = 3'd7
   } state_t;

   // bit 0 = SCL, bit 1 = SDA
   logic [1:0] line_in;
   logic [1:0] line_filt;
   logic [1:0] prev_reg;

   assign line_in = {i_sda, i_scl};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cond
         logic          meta_reg;
         logic          sync_reg;
         logic          filt_reg;
         logic [FW-1:0] cnt_reg;

         // Synchronize the bus line, then accept a new level only after a full run of equal samples
         always_ff @(posedge i_sysclk) begin
            if (i_arst) begin
               meta_reg <= 1'b1;
               sync_reg <= 1'b1;
               filt_reg <= 1'b1;
               cnt_reg  <= '0;
            end else begin
               meta_reg <= line_in[gi];
               sync_reg <= meta_reg;
               if (sync_reg != filt_reg) begin
                  if (cnt_reg == FW'(FILTER_LEN - 1)) begin
                     filt_reg <= sync_reg;
                     cnt_reg  <= '0;
                  end else begin
                     cnt_reg <= cnt_reg + FW'(1);
                  end
               end else begin
                  cnt_reg <= '0;
               end
            end
         end

         assign line_filt[gi] = filt_reg;
      end
   endgenerate

   // Previous filtered levels for edge and START/STOP detection
   always_ff @(posedge i_sysclk) begin
      if (i_arst) prev_reg <= 2'b11;
      else        prev_reg <= line_filt;
   end

   logic scl_rise, scl_fall, start_det, stop_det, sda_bit;
   assign sda_bit   = line_filt[1];
   assign scl_rise  = line_filt[0] & ~prev_reg[0];
   assign scl_fall  = ~line_filt[0] & prev_reg[0];
   assign start_det = line_filt[0] & prev_reg[0] & prev_reg[1] & ~line_filt[1];
   assign stop_det  = line_filt[0] & prev_reg[0] & ~prev_reg[1] & line_filt[1];

   state_t        state_reg;
   logic [3:0]    bit_cnt_reg;
   logic [7:0]    shift_reg;
   logic [7:0]    tx_shift_reg;
   logic          rw_reg;
   logic          ack_phase_reg;
   logic [1:0]    byte_idx_reg;
   logic [15:0]   ptr_reg;
   logic          rd_wait_reg;
   logic [HW-1:0] hold_cnt_reg;
   logic          pend_oe_reg;
   logic          pend_tx_reg;
   logic          oe_reg;
   logic          wr_en_reg;
   logic [15:0]   wr_addr_reg;
   logic [7:0]    wr_data_reg;
   logic          rd_req_reg;
   logic [15:0]   rd_addr_reg;
   logic          busy_reg;

   logic [7:0] rx_byte;
   assign rx_byte = {shift_reg[6:0], sda_bit};

   // Protocol FSM; SDA changes are queued on SCL fall and applied after the hold delay
   always_ff @(posedge i_sysclk) begin
      if (i_arst) begin
         state_reg     <= S_IDLE;
         bit_cnt_reg   <= '0;
         shift_reg     <= '0;
         tx_shift_reg  <= '0;
         rw_reg        <= 1'b0;
         ack_phase_reg <= 1'b0;
         byte_idx_reg  <= '0;
         ptr_reg       <= '0;
         rd_wait_reg   <= 1'b0;
         hold_cnt_reg  <= '0;
         pend_oe_reg   <= 1'b0;
         pend_tx_reg   <= 1'b0;
         oe_reg        <= 1'b0;
         wr_en_reg     <= 1'b0;
         wr_addr_reg   <= '0;
         wr_data_reg   <= '0;
         rd_req_reg    <= 1'b0;
         rd_addr_reg   <= '0;
         busy_reg      <= 1'b0;
      end else begin
         wr_en_reg   <= 1'b0;
         rd_req_reg  <= 1'b0;
         rd_wait_reg <= rd_req_reg;

         // Read data arrives one cycle after the request
         if (rd_wait_reg) begin
            tx_shift_reg <= i_rd_data;
            ptr_reg      <= ptr_reg + 16'd1;
         end

         // Data bits are resolved at apply time so read data latched after the fall is used
         if (hold_cnt_reg != '0) begin
            hold_cnt_reg <= hold_cnt_reg - HW'(1);
            if (hold_cnt_reg == HW'(1))
               oe_reg <= pend_tx_reg ? ~tx_shift_reg[7] : pend_oe_reg;
         end

         if (stop_det) begin
            state_reg     <= S_IDLE;
            oe_reg        <= 1'b0;
            hold_cnt_reg  <= '0;
            busy_reg      <= 1'b0;
            bit_cnt_reg   <= '0;
            ack_phase_reg <= 1'b0;
         end else if (start_det) begin
            state_reg     <= S_ADDR;
            oe_reg        <= 1'b0;
            hold_cnt_reg  <= '0;
            busy_reg      <= 1'b1;
            bit_cnt_reg   <= '0;
            ack_phase_reg <= 1'b0;
            byte_idx_reg  <= '0;
         end else begin
            case (state_reg)
               S_ADDR: begin
                  if (scl_rise) begin
                     shift_reg   <= rx_byte;
                     bit_cnt_reg <= bit_cnt_reg + 4'd1;
                     if (bit_cnt_reg == 4'd7) begin
                        bit_cnt_reg <= '0;
                        rw_reg      <= sda_bit;
                        state_reg   <= (shift_reg[6:0] == I2C_ID) ? S_ADDR_ACK : S_IGNORE;
                     end
                  end
               end
               S_ADDR_ACK: begin
                  if (scl_fall) begin
                     hold_cnt_reg <= HW'(HOLD_CYC);
                     if (!ack_phase_reg) begin
                        ack_phase_reg <= 1'b1;
                        pend_oe_reg   <= 1'b1;
                        pend_tx_reg   <= 1'b0;
                     end else begin
                        ack_phase_reg <= 1'b0;
                        bit_cnt_reg   <= '0;
                        pend_oe_reg   <= 1'b0;
                        if (rw_reg) begin
                           state_reg   <= S_TX;
                           rd_req_reg  <= 1'b1;
                           rd_addr_reg <= ptr_reg;
                           pend_tx_reg <= 1'b1;
                        end else begin
                           state_reg    <= S_RX;
                           byte_idx_reg <= '0;
                           pend_tx_reg  <= 1'b0;
                        end
                     end
                  end
               end
               S_RX: begin
                  if (scl_rise) begin
                     shift_reg   <= rx_byte;
                     bit_cnt_reg <= bit_cnt_reg + 4'd1;
                     if (bit_cnt_reg == 4'd7) begin
                        bit_cnt_reg <= '0;
                        state_reg   <= S_RX_ACK;
                        if (byte_idx_reg != 2'd2) byte_idx_reg <= byte_idx_reg + 2'd1;
                        case (byte_idx_reg)
                           2'd0:    ptr_reg[15:8] <= rx_byte;
                           2'd1:    ptr_reg[7:0]  <= rx_byte;
                           default: begin
                              wr_en_reg   <= 1'b1;
                              wr_addr_reg <= ptr_reg;
                              wr_data_reg <= rx_byte;
                              ptr_reg     <= ptr_reg + 16'd1;
                           end
                        endcase
                     end
                  end
               end
               S_RX_ACK: begin
                  if (scl_fall) begin
                     hold_cnt_reg <= HW'(HOLD_CYC);
                     pend_tx_reg  <= 1'b0;
                     if (!ack_phase_reg) begin
                        ack_phase_reg <= 1'b1;
                        pend_oe_reg   <= 1'b1;
                     end else begin
                        ack_phase_reg <= 1'b0;
                        pend_oe_reg   <= 1'b0;
                        state_reg     <= S_RX;
                     end
                  end
               end
               S_TX: begin
                  if (scl_rise) begin
                     tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
                     bit_cnt_reg  <= bit_cnt_reg + 4'd1;
                  end else if (scl_fall) begin
                     hold_cnt_reg <= HW'(HOLD_CYC);
                     pend_oe_reg  <= 1'b0;
                     if (bit_cnt_reg == 4'd8) begin
                        bit_cnt_reg <= '0;
                        pend_tx_reg <= 1'b0;
                        state_reg   <= S_TX_ACK;
                     end else begin
                        pend_tx_reg <= 1'b1;
                     end
                  end
               end
               S_TX_ACK: begin
                  if (scl_rise) begin
                     if (!sda_bit) begin
                        state_reg   <= S_TX;
                        bit_cnt_reg <= '0;
                        rd_req_reg  <= 1'b1;
                        rd_addr_reg <= ptr_reg;
                     end else begin
                        state_reg <= S_IGNORE;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign o_sda_oe  = oe_reg;
   assign o_wr_en   = wr_en_reg;
   assign o_wr_addr = wr_addr_reg;
   assign o_wr_data = wr_data_reg;
   assign o_rd_req  = rd_req_reg;
   assign o_rd_addr = rd_addr_reg;
   assign o_busy    = busy_reg;
   assign o_state   = state_reg;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-banged I2C master, register-store model and pointer model.
module tb_i2c_reg_target;

   localparam logic [6:0] ID = 7'h10;
   localparam int Q = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        srst = 1'b1;
   logic        scl_drv = 1'b1;
   logic        sda_drv = 1'b1;
   logic        sda_line;
   logic [7:0]  rd_data = 8'h00;
   logic        sda_oe, wr_en, rd_req, busy;
   logic [15:0] wr_addr, rd_addr;
   logic [7:0]  wr_data;
   logic [2:0]  state;

   assign sda_line = sda_drv & ~sda_oe;

   i2c_reg_target #(.I2C_ID(ID), .FILTER_LEN(3), .HOLD_CYC(4)) dut (
      .i_sysclk(clk), .i_arst(srst), .i_scl(scl_drv), .i_sda(sda_line),
      .o_sda_oe(sda_oe), .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
      .o_rd_req(rd_req), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
      .o_busy(busy), .o_state(state)
   );

   int compared = 0;
   int mismatched = 0;
   int oe_viol = 0;
   logic oe_prev = 1'b0;

   logic [23:0] wr_q[$], exp_wr_q[$];
   logic [15:0] rd_q[$], exp_rd_q[$];
   logic [15:0] m_ptr = 16'h0000;
   logic [7:0]  mem [65536];

   // External register store and bus observers
   always @(negedge clk) begin
      if (wr_en) wr_q.push_back({wr_addr, wr_data});
      if (rd_req) begin
         rd_q.push_back(rd_addr);
         rd_data <= mem[rd_addr];
      end
      if (sda_oe && !oe_prev && scl_drv) oe_viol++;
      oe_prev = sda_oe;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bus_start();
      sda_drv = 1'b1; wait_cyc(Q);
      scl_drv = 1'b1; wait_cyc(Q);
      sda_drv = 1'b0; wait_cyc(Q);
      scl_drv = 1'b0; wait_cyc(Q);
   endtask

   task automatic bus_stop();
      sda_drv = 1'b0; wait_cyc(Q);
      scl_drv = 1'b1; wait_cyc(Q);
      sda_drv = 1'b1; wait_cyc(Q);
   endtask

   task automatic write_bit(input logic b);
      sda_drv = b;    wait_cyc(Q);
      scl_drv = 1'b1; wait_cyc(2 * Q);
      scl_drv = 1'b0; wait_cyc(Q);
   endtask

   task automatic read_bit(output logic b);
      sda_drv = 1'b1; wait_cyc(Q);
      scl_drv = 1'b1; wait_cyc(Q);
      b = sda_line;   wait_cyc(Q);
      scl_drv = 1'b0; wait_cyc(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(b[i]);
      read_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] b, input logic nack);
      logic bt;
      for (int i = 7; i >= 0; i--) begin
         read_bit(bt);
         b[i] = bt;
      end
      write_bit(nack);
   endtask

   // Pointer/register model: first two bytes load the pointer, the rest are writes
   task automatic model_rx(input int idx, input logic [7:0] b);
      if (idx == 0)      m_ptr[15:8] = b;
      else if (idx == 1) m_ptr[7:0]  = b;
      else begin
         exp_wr_q.push_back({m_ptr, b});
         mem[m_ptr] = b;
         m_ptr = m_ptr + 16'd1;
      end
   endtask

   task automatic compare_wr(input string tag);
      wait_cyc(2);
      check({tag, " wr count"}, wr_q.size(), exp_wr_q.size());
      for (int i = 0; i < wr_q.size() && i < exp_wr_q.size(); i++)
         check({tag, " wr addr/data"}, wr_q[i], exp_wr_q[i]);
      $display("txn %s: %0d writes observed", tag, wr_q.size());
      wr_q.delete();
      exp_wr_q.delete();
   endtask

   task automatic compare_rd(input string tag);
      check({tag, " rd count"}, rd_q.size(), exp_rd_q.size());
      for (int i = 0; i < rd_q.size() && i < exp_rd_q.size(); i++)
         check({tag, " rd addr"}, rd_q[i], exp_rd_q[i]);
      $display("txn %s: %0d read requests observed", tag, rd_q.size());
      rd_q.delete();
      exp_rd_q.delete();
   endtask

   task automatic wr_txn(input logic [6:0] id, input logic [7:0] bytes[$], input logic do_stop, input string tag);
      logic ack;
      bus_start();
      write_byte({id, 1'b0}, ack);
      check({tag, " addr ack"}, ack, (id == ID) ? 1'b0 : 1'b1);
      for (int i = 0; i < bytes.size(); i++) begin
         write_byte(bytes[i], ack);
         if (id == ID) begin
            check({tag, " byte ack"}, ack, 1'b0);
            model_rx(i, bytes[i]);
         end else begin
            check({tag, " byte nack"}, ack, 1'b1);
            check({tag, " ignore state"}, state, 3'd7);
         end
      end
      if (do_stop) begin
         bus_stop();
         wait_cyc(8);
         check({tag, " idle state"}, state, 3'd0);
         check({tag, " busy low"}, busy, 1'b0);
      end
      compare_wr(tag);
   endtask

   task automatic rd_txn(input int n, input string tag);
      logic ack;
      logic [7:0] b;
      bus_start();
      write_byte({ID, 1'b1}, ack);
      check({tag, " rd addr ack"}, ack, 1'b0);
      for (int i = 0; i < n; i++) begin
         read_byte(b, (i == n - 1));
         check({tag, " rd data"}, b, mem[m_ptr]);
         exp_rd_q.push_back(m_ptr);
         m_ptr = m_ptr + 16'd1;
      end
      check({tag, " after nack"}, state, 3'd7);
      bus_stop();
      wait_cyc(8);
      check({tag, " idle state"}, state, 3'd0);
      compare_rd(tag);
   endtask

   initial begin
      logic [7:0]  bq[$];
      logic [15:0] p;
      logic        ack;
      int          n;

      for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
      mem[16'h0016] = 8'h02;
      mem[16'h0017] = 8'h19;

      // Reset state
      wait_cyc(6);
      check("rst oe", sda_oe, 1'b0);
      check("rst wr_en", wr_en, 1'b0);
      check("rst rd_req", rd_req, 1'b0);
      check("rst busy", busy, 1'b0);
      check("rst state", state, 3'd0);
      check("rst addr", {wr_addr, rd_addr}, 32'h0);
      srst = 1'b0;
      wait_cyc(10);

      bq = '{8'h01, 8'h00, 8'h01};
      wr_txn(ID, bq, 1'b1, "single_write");

      bq = '{8'h30, 8'h00, 8'hAA, 8'hBB, 8'hCC};
      wr_txn(ID, bq, 1'b1, "burst_write");

      bq = '{8'h00, 8'h16};
      wr_txn(ID, bq, 1'b0, "ptr_0016");
      rd_txn(2, "sr_read");

      bq = '{8'h01, 8'h02};
      wr_txn(7'h36, bq, 1'b1, "wrong_id");

      // Data byte cut short by STOP: pointer kept, nothing written
      bq = '{8'h12, 8'h34};
      bus_start();
      write_byte({ID, 1'b0}, ack);
      check("partial addr ack", ack, 1'b0);
      for (int i = 0; i < 2; i++) begin
         write_byte(bq[i], ack);
         model_rx(i, bq[i]);
      end
      for (int i = 0; i < 4; i++) write_bit(1'b1);
      bus_stop();
      compare_wr("partial");
      rd_txn(1, "read_after_partial");

      bq = '{8'hFF, 8'hFF, 8'h5C, 8'hC5};
      wr_txn(ID, bq, 1'b1, "wrap_write");

      // Single pointer byte before STOP only updates the high half
      m_ptr = 16'h0000;
      bq = '{8'h00, 8'h00};
      wr_txn(ID, bq, 1'b1, "ptr_clear");
      bq = '{8'h7E};
      wr_txn(ID, bq, 1'b1, "half_ptr");
      rd_txn(1, "read_half_ptr");

      // Idle glitch must not create START; glitch after START must not create STOP
      sda_drv = 1'b0; wait_cyc(1); sda_drv = 1'b1; wait_cyc(Q);
      check("glitch no start", busy, 1'b0);
      sda_drv = 1'b0; wait_cyc(Q);
      check("start busy", busy, 1'b1);
      sda_drv = 1'b1; wait_cyc(1); sda_drv = 1'b0; wait_cyc(Q);
      check("glitch no stop", {busy, state}, {1'b1, 3'd1});
      sda_drv = 1'b1; wait_cyc(Q);
      check("stop after glitch", busy, 1'b0);

      // Reset while the target drives a zero data bit
      bq = '{8'h40, 8'h00, 8'h00};
      wr_txn(ID, bq, 1'b1, "zero_store");
      bq = '{8'h40, 8'h00};
      wr_txn(ID, bq, 1'b1, "ptr_4000");
      bus_start();
      write_byte({ID, 1'b1}, ack);
      check("tx addr ack", ack, 1'b0);
      exp_rd_q.push_back(16'h4000);
      check("tx driving", {sda_oe, state}, {1'b1, 3'd5});
      srst = 1'b1; wait_cyc(1);
      check("mid-tx reset", {sda_oe, state}, {1'b0, 3'd0});
      srst = 1'b0;
      compare_rd("pre_reset_read");
      m_ptr = 16'h0000;
      bus_stop();
      wait_cyc(8);
      rd_txn(1, "read_after_reset");

      // Randomized write-then-readback through repeated START
      for (int k = 0; k < 3; k++) begin
         p = 16'($urandom);
         n = $urandom_range(1, 3);
         bq = '{p[15:8], p[7:0]};
         for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
         wr_txn(ID, bq, 1'b1, "rand_write");
         bq = '{p[15:8], p[7:0]};
         wr_txn(ID, bq, 1'b0, "rand_ptr");
         rd_txn(n + 1, "rand_read");
      end

      check("oe raised while scl high", oe_viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
